exec_unit: RTL and testbench



---
 rtl/exec_unit.sv | 91 +++++++++
 tb/tb_exec_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/exec_unit.sv
// rtl/exec_unit.sv - execute stage: ALU control decode, 32-bit ALU, PC adders, registered capture
// Optional feature macro: EXEC_SLT_EN (signed set-less-than decode and comparator)
module exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       alu_op,
  input  logic [6:0]       funct7,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] imm,
  input  logic             branch,
  output logic [3:0]       alu_ctl,
  output logic [WIDTH-1:0] pc4,
  output logic [WIDTH-1:0] pc_branch,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic [WIDTH-1:0] pc_next
);

  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_XOR = 4'b0011;
  localparam logic [3:0] CTL_SUB = 4'b0110;
  localparam logic [3:0] CTL_SLT = 4'b0111;
  localparam logic [3:0] CTL_INV = 4'b1111;

  logic [WIDTH-1:0] alu_comb;
  logic             zero_comb;
  logic             unused_funct7;

  // Only funct7[5] distinguishes ADD from SUB; the other bits are don't-care.
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  always_comb begin
    alu_ctl = CTL_INV;
    case (alu_op)
      2'b00: alu_ctl = CTL_ADD;
      2'b01: alu_ctl = CTL_SUB;
      default: begin
        case (funct3)
          3'b000:  alu_ctl = (alu_op == 2'b10 && funct7[5]) ? CTL_SUB : CTL_ADD;
          3'b111:  alu_ctl = CTL_AND;
          3'b110:  alu_ctl = CTL_OR;
          3'b100:  alu_ctl = CTL_XOR;
`ifdef EXEC_SLT_EN
          3'b010:  alu_ctl = CTL_SLT;
`endif
          default: alu_ctl = CTL_INV;
        endcase
      end
    endcase
  end

  always_comb begin
    alu_comb = '0;
    case (alu_ctl)
      CTL_ADD: alu_comb = a + b;
      CTL_SUB: alu_comb = a - b;
      CTL_AND: alu_comb = a & b;
      CTL_OR:  alu_comb = a | b;
      CTL_XOR: alu_comb = a ^ b;
`ifdef EXEC_SLT_EN
      CTL_SLT: alu_comb = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
`endif
      default: alu_comb = '0;
    endcase
  end

  assign zero_comb = (alu_comb == '0);
  assign pc4       = pc + WIDTH'(4);
  assign pc_branch = pc + (imm << 1);

  // Branch decision uses this cycle's combinational zero, not the registered flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      alu_result <= '0;
      zero       <= 1'b0;
      pc_next    <= '0;
    end else begin
      alu_result <= alu_comb;
      zero       <= zero_comb;
      pc_next    <= (branch && zero_comb) ? pc_branch : pc4;
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// tb/tb_exec_unit.sv - directed and randomized checks of exec_unit against a behavioural model
module tb_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  alu_op;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [31:0] a, b, pc, imm;
  logic        branch;
  logic [3:0]  alu_ctl;
  logic [31:0] pc4, pc_branch, alu_result, pc_next;
  logic        zero;

  int n_assert = 0;
  int n_fail   = 0;

  exec_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .alu_op(alu_op), .funct7(funct7), .funct3(funct3),
    .a(a), .b(b), .pc(pc), .imm(imm), .branch(branch),
    .alu_ctl(alu_ctl), .pc4(pc4), .pc_branch(pc_branch),
    .alu_result(alu_result), .zero(zero), .pc_next(pc_next)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [3:0] m_ctl(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3);
    if (op == 2'd0) return 4'd2;
    if (op == 2'd1) return 4'd6;
    case (f3)
      3'd0: return (op == 2'd2 && f7[5]) ? 4'd6 : 4'd2;
      3'd7: return 4'd0;
      3'd6: return 4'd1;
      3'd4: return 4'd3;
`ifdef EXEC_SLT_EN
      3'd2: return 4'd7;
`endif
      default: return 4'd15;
    endcase
  endfunction

  function automatic logic [31:0] m_alu(input logic [3:0] ctl, input logic [31:0] x, input logic [31:0] y);
    int sx, sy;
    sx = x;
    sy = y;
    case (ctl)
      4'd2: return x + y;
      4'd6: return x - y;
      4'd0: return x & y;
      4'd1: return x | y;
      4'd3: return x ^ y;
      4'd7: return (sx < sy) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic step(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                      input logic [31:0] ta, input logic [31:0] tb_v, input logic [31:0] tpc,
                      input logic [31:0] timm, input logic br);
    logic [3:0]  ectl;
    logic [31:0] eres, epc4, epb, enext;
    alu_op = op; funct7 = f7; funct3 = f3;
    a = ta; b = tb_v; pc = tpc; imm = timm; branch = br;
    ectl  = m_ctl(op, f7, f3);
    eres  = m_alu(ectl, ta, tb_v);
    epc4  = tpc + 32'd4;
    epb   = tpc + timm * 2;
    enext = (br && eres == 32'd0) ? epb : epc4;
    #1;
    chk("alu_ctl", {28'd0, alu_ctl}, {28'd0, ectl});
    chk("pc4", pc4, epc4);
    chk("pc_branch", pc_branch, epb);
    @(posedge clk);
    #1;
    chk("alu_result", alu_result, eres);
    chk("zero", {31'd0, zero}, {31'd0, (eres == 32'd0)});
    chk("pc_next", pc_next, enext);
  endtask

  initial begin
    rst = 1'b0; alu_op = 2'b00; funct7 = '0; funct3 = '0;
    a = 32'd5; b = 32'd3; pc = 32'd0; imm = 32'd0; branch = 1'b0;

    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk("rst_alu_result", alu_result, 32'd0);
      chk("rst_zero", {31'd0, zero}, 32'd0);
      chk("rst_pc_next", pc_next, 32'd0);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_result", alu_result, 32'd8);
    chk("post_rst_pc_next", pc_next, 32'd4);

    step(2'b10, 7'b0100000, 3'b000, 32'd3, 32'd5, 32'h0, 32'h0, 1'b0);
    chk("sub_ctl_const", {28'd0, alu_ctl}, 32'h6);
    chk("sub_result_const", alu_result, 32'hFFFFFFFE);
    step(2'b10, 7'b0000000, 3'b000, 32'd3, 32'd5, 32'h0, 32'h0, 1'b0);
    chk("add_result_const", alu_result, 32'd8);

    step(2'b00, 7'd0, 3'd0, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h0, 1'b0);
    chk("wrap_zero_const", {31'd0, zero}, 32'd1);
    step(2'b10, 7'd0, 3'b111, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0, 32'h0, 1'b0);
    chk("and_const", alu_result, 32'h00F000F0);
    step(2'b11, 7'd0, 3'b100, 32'h12345678, 32'h12345678, 32'h0, 32'h0, 1'b0);
    chk("xor_zero_const", {31'd0, zero}, 32'd1);
    step(2'b11, 7'b0100000, 3'b000, 32'd3, 32'd5, 32'h0, 32'h0, 1'b0);
    chk("itype_ignores_f7", alu_result, 32'd8);

    step(2'b10, 7'd0, 3'b010, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h0, 1'b0);
`ifdef EXEC_SLT_EN
    chk("slt_neg_lt_pos", alu_result, 32'd1);
    step(2'b10, 7'd0, 3'b010, 32'd1, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b0);
    chk("slt_pos_lt_neg", alu_result, 32'd0);
`else
    chk("slt_disabled_ctl", {28'd0, alu_ctl}, 32'hF);
    chk("slt_disabled_result", alu_result, 32'd0);
`endif

    step(2'b01, 7'd0, 3'd0, 32'd7, 32'd7, 32'h100, 32'h10, 1'b1);
    chk("br_taken_const", pc_next, 32'h120);
    step(2'b01, 7'd0, 3'd0, 32'd7, 32'd8, 32'h100, 32'h10, 1'b1);
    chk("br_not_taken_const", pc_next, 32'h104);
    step(2'b01, 7'd0, 3'd0, 32'd7, 32'd7, 32'h100, 32'h10, 1'b0);
    chk("no_branch_const", pc_next, 32'h104);
    step(2'b01, 7'd0, 3'd0, 32'd1, 32'd1, 32'hFFFFFFF0, 32'h80000008, 1'b1);
    chk("pc_branch_wrap", pc_next, 32'h00000000);

    step(2'b00, 7'd0, 3'd0, 32'd1, 32'd2, 32'hFFFFFFFC, 32'h0, 1'b0);
    chk("pc4_wrap_const", pc_next, 32'd0);
    step(2'b10, 7'd0, 3'b001, 32'd9, 32'd4, 32'h40, 32'h8, 1'b1);
    chk("invalid_ctl_const", {28'd0, alu_ctl}, 32'hF);
    chk("invalid_zero_const", {31'd0, zero}, 32'd1);
    chk("invalid_branch_taken", pc_next, 32'h50);

    // Reset asserted mid-stream must override the capture on that edge.
    alu_op = 2'b00; a = 32'd1; b = 32'd1; rst = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_result", alu_result, 32'd0);
    chk("mid_rst_pc_next", pc_next, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 300; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      step(2'($urandom_range(0, 3)), 7'($urandom), 3'($urandom), ra, rb,
           $urandom, $urandom, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
